// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, exception codes and FSM states for the pipeline controller.
package pipe_ctrl_pkg;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, REFILL = 2'd2} state_t;
endpackage

// File: rtl/stall_wdog.sv
// stall_wdog: consecutive-stall counter; hit flags the final cycle before the limit expires.
module stall_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    logic [15:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else
            count <= clr ? '0 : inc ? count + 16'd1 : count;
    assign hit = count == 16'(LIMIT - 1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall priority decode plus RUN/FLUSH/REFILL redirect FSM with a stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_timeout
);
    state_t      state, state_nxt;
    logic [31:0] target, target_nxt;
    logic [5:0]  req_stall;
    logic        run, stalling, exc_take, wdog_hit, go;

    assign req_stall = stallreq_from_mem ? STALL_MEM :
                       stallreq_from_ex  ? STALL_EX  :
                       stallreq_from_id  ? STALL_ID  : STALL_NONE;
    assign run          = state == RUN;
    assign stalling     = req_stall != STALL_NONE;
    assign exc_take     = run && excepttype_i != ZERO_WORD;
    assign wdog_timeout = run && stalling && wdog_hit;
    assign go           = exc_take || wdog_timeout;

    // Leaving RUN clears the count so a refill never inherits stale stall history.
    stall_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clk (clk),
        .rst (rst),
        .inc (run && stalling),
        .clr (!run || !stalling || go),
        .hit (wdog_hit)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= RUN;
            target <= ZERO_WORD;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
        end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = ZERO_WORD;
        case (state)
            RUN: begin
                stall      = go ? STALL_NONE : req_stall;
                state_nxt  = go ? FLUSH : RUN;
                // An exception outranks a simultaneous watchdog fire for the redirect target.
                target_nxt = !go ? target :
                             (exc_take && excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end
            FLUSH: begin
                flush     = 1'b1;
                new_pc    = target;
                state_nxt = REFILL;
            end
            REFILL: begin
                stall     = req_stall;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven scoreboard bench for pipe_ctrl with WDOG_LIMIT=8, plus reset corner sequences.
module tb_pipe_ctrl;
    typedef struct {
        logic        id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        wd;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        id = 1'b0, ex = 1'b0, mem = 1'b0;
    logic [31:0] exc = '0, epc = '0;
    logic [5:0]  stall;
    logic        flush, wdog_timeout;
    logic [31:0] new_pc;
    vec_t        vecs[$];
    vec_t        sb[$];
    int          checks = 0, errors = 0;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(id), .stallreq_from_ex(ex), .stallreq_from_mem(mem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, req);
        end
    endtask

    task automatic add(logic i, logic e, logic m, logic [31:0] x, logic [31:0] p,
                       logic [5:0] s, logic f, logic [31:0] pc, logic w, int n = 1);
        vec_t t;
        t.id = i; t.ex = e; t.mem = m; t.exc = x; t.epc = p;
        t.st = s; t.fl = f; t.pc = pc; t.wd = w;
        for (int k = 0; k < n; k++) vecs.push_back(t);
    endtask

    task automatic cyc(vec_t t, int idx);
        vec_t e;
        @(posedge clk);
        #1;
        id = t.id; ex = t.ex; mem = t.mem; exc = t.exc; epc = t.epc;
        sb.push_back(t);
        #2;
        e = sb.pop_front();
        chk($sformatf("v%0d stall", idx), {26'd0, stall}, {26'd0, e.st});
        chk($sformatf("v%0d flush", idx), {31'd0, flush}, {31'd0, e.fl});
        chk($sformatf("v%0d new_pc", idx), new_pc, e.pc);
        chk($sformatf("v%0d wdog", idx), {31'd0, wdog_timeout}, {31'd0, e.wd});
    endtask

    initial begin
        // Stall priority decode in RUN.
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        add(0,1,0, 32'h0, 0, 6'b001111, 0, 0, 0);
        add(0,1,1, 32'h0, 0, 6'b011111, 0, 0, 0);
        add(1,0,0, 32'h0, 0, 6'b000111, 0, 0, 0);
        add(1,1,1, 32'h0, 0, 6'b011111, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        // Exception beats mem stall; stale code ignored in FLUSH/REFILL.
        add(0,0,1, 32'h8, 0, 6'b000000, 0, 0, 0);
        add(0,0,1, 32'h8, 0, 6'b000000, 1, 32'h20, 0);
        add(0,1,0, 32'h8, 0, 6'b001111, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        // ERET redirects to EPC.
        add(0,0,0, 32'he, 32'h1234, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 1, 32'h1234, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0, 2);
        // Held through N+2: one pulse only.
        add(0,0,0, 32'h4, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h4, 0, 6'b000000, 1, 32'h20, 0);
        add(0,0,0, 32'h4, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        // Held through N+3: second pulse at N+4.
        add(0,0,0, 32'h4, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h4, 0, 6'b000000, 1, 32'h20, 0);
        add(0,0,0, 32'h4, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h4, 0, 6'b000000, 0, 0, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 1, 32'h20, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0, 2);
        // Watchdog fires on the 8th stalled cycle.
        add(1,0,0, 32'h0, 0, 6'b000111, 0, 0, 0, 7);
        add(1,0,0, 32'h0, 0, 6'b000000, 0, 0, 1);
        add(1,0,0, 32'h0, 0, 6'b000000, 1, 32'h20, 0);
        add(1,0,0, 32'h0, 0, 6'b000111, 0, 0, 0, 2);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        // Exception and watchdog together: exception target, pulse still seen.
        add(0,0,1, 32'h0, 0, 6'b011111, 0, 0, 0, 7);
        add(0,0,1, 32'he, 32'h1234_5678, 6'b000000, 0, 0, 1);
        add(0,0,0, 32'h0, 0, 6'b000000, 1, 32'h1234_5678, 0);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0, 2);
        // An unstalled cycle restarts the count.
        add(1,0,0, 32'h0, 0, 6'b000111, 0, 0, 0, 4);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);
        add(1,0,0, 32'h0, 0, 6'b000111, 0, 0, 0, 7);
        add(0,0,0, 32'h0, 0, 6'b000000, 0, 0, 0);

        // Reset state, with stall still decoded combinationally.
        mem = 1'b1;
        #2;
        chk("rst stall", {26'd0, stall}, 32'h1f);
        chk("rst flush", {31'd0, flush}, 0);
        chk("rst new_pc", new_pc, 0);
        chk("rst wdog", {31'd0, wdog_timeout}, 0);
        mem = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], i);

        // Reset mid-FLUSH aborts the redirect.
        @(posedge clk);
        #1 exc = 32'h8;
        @(posedge clk);
        #1 exc = 32'h0;
        #1 chk("mid flush", {31'd0, flush}, 1);
        rst = 1'b1;
        #1;
        chk("async flush", {31'd0, flush}, 0);
        chk("async new_pc", new_pc, 0);
        ex = 1'b1;
        #1 chk("rst ex stall", {26'd0, stall}, 32'h0f);
        ex = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2 chk($sformatf("post rst %0d", k), {31'd0, flush}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, 32'h0000_0020, redirect target for all non-ERET exceptions.
REQ-002 SHALL have parameter WDOG_LIMIT, 1024, consecutive stall cycles that trigger a watchdog timeout.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stallreq_from_id  input  1  ID stage requests a hold.
REQ-006 SHALL have port stallreq_from_ex  input  1  EX stage requests a hold (multi-cycle op).
REQ-007 SHALL have port stallreq_from_mem  input  1  MEM stage requests a hold (bus wait).
REQ-008 SHALL have port excepttype_i  input  32  exception code from MEM; zero means none.
REQ-009 SHALL have port cp0_epc_i  input  32  EPC value used for ERET.
REQ-010 SHALL have port stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-011 SHALL have port flush  output  1  clears all pipeline registers for one cycle.
REQ-012 SHALL have port new_pc  output  32  PC redirect target, valid only while flush=1.
REQ-013 SHALL have port wdog_timeout  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-014 SHALL implement a registered FSM with states RUN, FLUSH, REFILL.
REQ-015 In RUN with excepttype_i==0, stall SHALL be combinational: mem req -> 6'b011111, else ex req -> 6'b001111, else id req -> 6'b000111, else 6'b000000 (mem highest priority).
REQ-016 In RUN with excepttype_i!=0, SHALL latch target (cp0_epc_i if code 32'h0000_000e, else EXC_VECTOR), force stall=0 that cycle, and go to FLUSH next cycle.
REQ-017 Exception SHALL take priority over every stall request in the same cycle.
REQ-018 In FLUSH, flush SHALL be 1 for exactly one cycle, new_pc SHALL equal the latched target, stall SHALL be 0; next state REFILL.
REQ-019 In REFILL, flush=0, new_pc=0, stall per REQ-015 from requests, excepttype_i SHALL be ignored for this one cycle; next state RUN.
REQ-020 excepttype_i SHALL be ignored in FLUSH and REFILL (no re-trigger from stale MEM contents).
REQ-021 A 16-bit watchdog counter SHALL increment each RUN cycle with stall!=0, clear on any RUN cycle with stall==0, and clear on leaving RUN.
REQ-022 When the counter reaches WDOG_LIMIT-1 while stall!=0, SHALL pulse wdog_timeout one cycle, latch EXC_VECTOR, force stall=0, and go to FLUSH next cycle.
REQ-023 Simultaneous exception and watchdog SHALL resolve to the exception target; wdog_timeout still pulses.
REQ-024 Outside FLUSH, flush SHALL be 0 and new_pc SHALL be 32'h0.
REQ-025 Latency: exception or timeout at cycle N -> flush=1 at cycle N+1 -> normal stall handling from N+2, exceptions re-accepted from N+3.

Reset
REQ-026 On rst=1, asynchronously: state=RUN, watchdog counter=0, latched target=0, flush=0, new_pc=0, wdog_timeout=0.
REQ-027 stall SHALL still follow REQ-015 combinationally during and after reset (no registered stall state).
REQ-028 Reset asserted in FLUSH or REFILL SHALL abort the redirect; no flush pulse after release.

Structure
REQ-029 Stall encodings, exception codes (ERET 32'h0000_000e), FSM state encodings and ZeroWord SHALL live in the shared define include.
REQ-030 Watchdog counter SHALL be one sub-module, stall_wdog (count, clear, limit-hit output); FSM and stall decode stay in pipe_ctrl.

Verification
REQ-031 stallreq_from_ex=1 only, RUN -> stall=6'b001111, flush=0; add mem=1 -> stall=6'b011111.
REQ-032 excepttype_i=32'h8 with stallreq_from_mem=1 at cycle N -> stall=0 at N; flush=1, new_pc=32'h20 at N+1; flush=0 at N+2.
REQ-033 excepttype_i=32'he, cp0_epc_i=32'h0000_1234 -> next cycle flush=1, new_pc=32'h0000_1234.
REQ-034 WDOG_LIMIT=8, stallreq_from_id held -> wdog_timeout pulse on 8th stalled cycle, flush=1 with new_pc=32'h20 the cycle after.
REQ-035 Exception held for 4 cycles -> exactly one flush pulse (N+1); second pulse only if still nonzero at N+3.
REQ-036 rst asserted mid-FLUSH -> flush=0 immediately (asynchronous), state RUN after release, no further flush.
